chess_clock_ctrl: RTL and testbench
===================================

// Module: chess_clock_ctrl
// PURPOSE
//   N-player chess clock core: one prescaler, N min:sec down-counters, and a turn/run FSM.
//   Adds per-move Fischer increment, pause/resume and a registered flag-fall (timeout)
//   with loser index. Sits between the debounced push-button inputs and the 7-segment
//   display driver. Generalises the two-player countdown with a single FSM-driven timer bank.
// PARAMETERS
//   N_PLAYERS  2            number of timers/players, legal 2..8
//   TICK_DIV   100_000_000  clk cycles per 1 s tick (100 MHz board clock)
//   MIN_W      6            minute field width; minutes saturate at 2**MIN_W-1
//   PW         $clog2(N_PLAYERS)  player index width (localparam, min 1)
// PORTS
//   clk       in   1            system clock, rising edge
//   reset_n   in   1            asynchronous reset, active low
//   load      in   1            level/pulse: preset all timers to time_min:00, go IDLE
//   time_min  in   MIN_W        initial minutes, sampled on load
//   inc_sec   in   6            Fischer increment in seconds (0..59), sampled on move
//   start     in   1            1-cycle pulse: IDLE/PAUSED -> RUN
//   pause     in   1            1-cycle pulse: RUN -> PAUSED
//   move      in   1            1-cycle pulse: active player ends turn
//   active    out  PW           index of player whose clock runs/would run
//   min_bus   out  N_PLAYERS*MIN_W  minutes, player i at [i*MIN_W +: MIN_W]
//   sec_bus   out  N_PLAYERS*6  seconds 0..59, player i at [i*6 +: 6]
//   running   out  1            1 while state == RUN
//   timeout   out  1            1 while state == FLAG
//   loser     out  PW           player whose flag fell; valid while timeout=1
// BEHAVIOUR
//   Reset (async, reset_n=0): all timers 0:00, state IDLE, active=0, running=0,
//     timeout=0, loser=0, prescaler=0. All outputs registered.
//   States: IDLE, RUN, PAUSED, FLAG. Priority per cycle: load > pause > move > start.
//     load (any state): timers <= time_min:00, active<=0, loser<=0, prescaler<=0, -> IDLE.
//     IDLE/PAUSED + start -> RUN. RUN + pause -> PAUSED. FLAG: only load exits.
//     start in RUN/FLAG, pause outside RUN, move outside RUN: ignored.
//   Prescaler: counts 0..TICK_DIV-1 only in RUN; holds in PAUSED; cleared on load and
//     on every accepted move. tick = (count == TICK_DIV-1) in RUN.
//   Tick on active timer: sec>0 -> sec-1; sec==0,min>0 -> min-1, sec=59.
//     If result is 0:00: next cycle state=FLAG, timeout=1, loser=active, running=0.
//   Timer already 0:00 at start (time_min=0): RUN lasts one cycle, then FLAG, loser=active.
//   Accepted move (RUN): active timer += inc_sec: s=sec+inc_sec; s>=60 -> sec=s-60, min+1.
//     Min overflow saturates at (2**MIN_W-1):59. active <= (active+1) mod N_PLAYERS.
//     Effects visible the cycle after move.
//   move + tick same cycle: tick applied first; if tick reaches 0:00 -> FLAG, move dropped;
//     else increment added to decremented value, then turn passes.
//   pause + tick same cycle: pause wins, tick dropped, prescaler holds at TICK_DIV-1
//     and fires the first cycle after resume.
//   Non-active timers never change except on load/reset. inc_sec>59 is clamped to 59.
//   Reset asserted mid-RUN: immediate return to reset values, no partial update.
// TESTING
//   T1 TICK_DIV=4, N=2: reset, load time_min=1, start -> p0 1:00, 0:59 after 4 clks; p1 stays 1:00.
//   T2 inc_sec=5, p0 at 0:57, move -> p0 1:02, active=1; prescaler restarts, p1 ticks 4 clks later.
//   T3 p1 at 0:01, tick -> 0:00, next cycle timeout=1, loser=1, running=0; start/move ignored.
//   T4 pause in RUN for 20 clks -> all timers frozen; start -> ticks resume, no lost/extra tick.
//   T5 N=3, MIN_W=6, p2 at 63:58, inc_sec=10, move -> p2 63:59, active wraps to 0.
//   T6 move and tick same cycle at 0:01 -> FLAG, loser=mover; then load mid-FLAG -> IDLE, timers preset.

Source files
------------

// File: rtl/chess_clock_ctrl.sv
// chess_clock_ctrl -- N-player chess clock core.
//   One shared 1 s prescaler, N min:sec down-counters (one lane per player),
//   and a turn/run FSM with Fischer increment, pause/resume and flag-fall.
// Ports:
//   clk, reset_n       clock (rising edge), async active-low reset
//   load               preset all timers to time_min:00, return to IDLE
//   time_min           initial minutes (sampled on load)
//   inc_sec            Fischer increment seconds (sampled on move, clamped to 59)
//   start/pause/move   1-cycle control pulses
//   active             player whose clock runs
//   min_bus/sec_bus    per-player minutes/seconds, player i at [i*W +: W]
//   running/timeout    state == RUN / state == FLAG
//   loser              player whose flag fell (valid while timeout)

// One player's min:sec timer. A same-cycle tick and increment are applied
// in that order: the increment is added to the decremented value.
module chess_clock_lane #(
    parameter int MIN_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld,
    input  logic [MIN_W-1:0] ld_min,
    input  logic             dec,
    input  logic             add,
    input  logic [5:0]       inc,
    output logic [MIN_W-1:0] tmin,
    output logic [5:0]       tsec,
    output logic             dz
);
    localparam logic [MIN_W-1:0] MAXM  = {MIN_W{1'b1}};
    localparam logic [MIN_W-1:0] M_ONE = MIN_W'(1);

    logic [MIN_W-1:0] dmin, amin;
    logic [5:0]       dsec, asec;
    logic [6:0]       ssum;

    always_comb begin
        dmin = tmin;
        dsec = tsec;
        // 0:00 never decrements; the FSM flags before that can matter
        if (dec && (tmin != '0 || tsec != '0)) begin
            if (tsec != 6'd0) begin
                dsec = tsec - 6'd1;
            end else begin
                dmin = tmin - M_ONE;
                dsec = 6'd59;
            end
        end
        // dz reflects the post-tick value, so it also covers "already 0:00"
        dz   = (dmin == '0) && (dsec == 6'd0);
        ssum = {1'b0, dsec} + {1'b0, inc};
        amin = dmin;
        asec = ssum[5:0];
        if (ssum >= 7'd60) begin
            if (dmin == MAXM) begin
                amin = MAXM;
                asec = 6'd59;
            end else begin
                amin = dmin + M_ONE;
                asec = 6'(ssum - 7'd60);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmin <= '0;
            tsec <= '0;
        end else if (ld) begin
            tmin <= ld_min;
            tsec <= '0;
        end else if (add) begin
            tmin <= amin;
            tsec <= asec;
        end else if (dec) begin
            tmin <= dmin;
            tsec <= dsec;
        end
    end
endmodule

module chess_clock_ctrl #(
    parameter int N_PLAYERS = 2,
    parameter int TICK_DIV  = 100_000_000,
    parameter int MIN_W     = 6,
    localparam int PW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [MIN_W-1:0]          time_min,
    input  logic [5:0]                inc_sec,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      move,
    output logic [PW-1:0]             active,
    output logic [N_PLAYERS*MIN_W-1:0] min_bus,
    output logic [N_PLAYERS*6-1:0]    sec_bus,
    output logic                      running,
    output logic                      timeout,
    output logic [PW-1:0]             loser
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, FLAG} state_t;

    state_t  state;
    logic [CW-1:0] pcnt;

    logic [N_PLAYERS-1:0][MIN_W-1:0] min_arr;
    logic [N_PLAYERS-1:0][5:0]       sec_arr;
    logic [N_PLAYERS-1:0]            dz, dec_en, add_en;

    logic [5:0]    inc_c;
    logic          tick, run_tick, expire, mv_ok;
    logic [PW-1:0] nxt_active;

    assign inc_c    = (inc_sec > 6'd59) ? 6'd59 : inc_sec;
    assign tick     = (state == RUN) && (pcnt == TC_LAST);
    // pause (and load) suppress the tick; the prescaler then holds at its
    // last count and fires on the first RUN cycle after resume
    assign run_tick = tick && !pause && !load;
    assign expire   = (state == RUN) && !pause && dz[active];
    // a move that coincides with flag-fall is dropped
    assign mv_ok    = (state == RUN) && move && !pause && !load && !expire;
    assign nxt_active = (active == PW'(N_PLAYERS - 1)) ? '0 : active + PW'(1);

    assign min_bus = min_arr;
    assign sec_bus = sec_arr;

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_lane
        assign dec_en[i] = run_tick && (active == PW'(i));
        assign add_en[i] = mv_ok && (active == PW'(i));
        chess_clock_lane #(.MIN_W(MIN_W)) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .ld     (load),
            .ld_min (time_min),
            .dec    (dec_en[i]),
            .add    (add_en[i]),
            .inc    (inc_c),
            .tmin   (min_arr[i]),
            .tsec   (sec_arr[i]),
            .dz     (dz[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pcnt    <= '0;
            active  <= '0;
            loser   <= '0;
            running <= 1'b0;
            timeout <= 1'b0;
        end else if (load) begin
            state   <= IDLE;
            pcnt    <= '0;
            active  <= '0;
            loser   <= '0;
            running <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, PAUSED: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (expire) begin
                        state   <= FLAG;
                        running <= 1'b0;
                        timeout <= 1'b1;
                        loser   <= active;
                    end else if (mv_ok) begin
                        active <= nxt_active;
                        pcnt   <= '0;
                    end else begin
                        pcnt <= tick ? '0 : pcnt + CW'(1);
                    end
                end
                FLAG: begin
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Scoreboard bench for chess_clock_ctrl: two instances (2 players and
// 3 players, TICK_DIV=4) share one set of control inputs. Stimulus pushes
// expected output snapshots; a negedge monitor pops and compares them.
module tb_chess_clock_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0, move = 1'b0;
    logic [5:0]  time_min = '0, inc_sec = '0;

    logic [0:0]  act1, los1;
    logic [11:0] min_bus1, sec_bus1;
    logic        run1, to1;
    logic [1:0]  act2, los2;
    logic [17:0] min_bus2, sec_bus2;
    logic        run2, to2;

    chess_clock_ctrl #(.N_PLAYERS(2), .TICK_DIV(4), .MIN_W(6)) dut1 (
        .clk(clk), .reset_n(reset_n), .load(load), .time_min(time_min),
        .inc_sec(inc_sec), .start(start), .pause(pause), .move(move),
        .active(act1), .min_bus(min_bus1), .sec_bus(sec_bus1),
        .running(run1), .timeout(to1), .loser(los1));

    chess_clock_ctrl #(.N_PLAYERS(3), .TICK_DIV(4), .MIN_W(6)) dut2 (
        .clk(clk), .reset_n(reset_n), .load(load), .time_min(time_min),
        .inc_sec(inc_sec), .start(start), .pause(pause), .move(move),
        .active(act2), .min_bus(min_bus2), .sec_bus(sec_bus2),
        .running(run2), .timeout(to2), .loser(los2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        int          sel;
        int          due;
        int          act;
        logic [17:0] mn;
        logic [17:0] sc;
        bit          run;
        bit          to;
        int          los;
    } exp_t;

    exp_t q[$];
    int nvec = 0, nbad = 0;

    task automatic expv(input string tag, input int sel, input int act,
                        input int m0, input int s0, input int m1, input int s1,
                        input int m2, input int s2,
                        input bit run, input bit to, input int los);
        exp_t e;
        e.tag = tag; e.sel = sel; e.due = cyc; e.act = act;
        e.mn  = {6'(m2), 6'(m1), 6'(m0)};
        e.sc  = {6'(s2), 6'(s1), 6'(s0)};
        e.run = run; e.to = to; e.los = los;
        q.push_back(e);
    endtask

    // monitor: compares every snapshot that is due this cycle
    always @(negedge clk) begin
        exp_t e;
        logic [17:0] gm, gs;
        int ga, gl;
        bit gr, gt;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.sel == 1) begin
                gm = {6'b0, min_bus1}; gs = {6'b0, sec_bus1};
                ga = int'(act1); gl = int'(los1); gr = run1; gt = to1;
            end else begin
                gm = min_bus2; gs = sec_bus2;
                ga = int'(act2); gl = int'(los2); gr = run2; gt = to2;
            end
            nvec++;
            if (gm !== e.mn || gs !== e.sc || ga != e.act || gl != e.los ||
                gr !== e.run || gt !== e.to || e.due != cyc) begin
                nbad++;
                $display("FAIL %s: got act=%0d min=%h sec=%h run=%0b to=%0b loser=%0d, want act=%0d min=%h sec=%h run=%0b to=%0b loser=%0d",
                         e.tag, ga, gm, gs, gr, gt, gl,
                         e.act, e.mn, e.sc, e.run, e.to, e.los);
            end
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int m);
        time_min = 6'(m); load = 1'b1; cyc_n(1); load = 1'b0;
    endtask
    task automatic do_start();
        start = 1'b1; cyc_n(1); start = 1'b0;
    endtask
    task automatic do_pause();
        pause = 1'b1; cyc_n(1); pause = 1'b0;
    endtask
    task automatic do_move(input int inc);
        inc_sec = 6'(inc); move = 1'b1; cyc_n(1); move = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // reset state
        cyc_n(3);
        expv("rst1", 1, 0, 0,0, 0,0, 0,0, 0,0, 0);
        expv("rst2", 2, 0, 0,0, 0,0, 0,0, 0,0, 0);
        reset_n = 1'b1;
        cyc_n(1);
        expv("rst_rel", 1, 0, 0,0, 0,0, 0,0, 0,0, 0);

        // T1: load 1:00, start, first tick after 4 clocks
        do_load(1);
        expv("t1_load", 1, 0, 1,0, 1,0, 0,0, 0,0, 0);
        do_start();
        expv("t1_start", 1, 0, 1,0, 1,0, 0,0, 1,0, 0);
        cyc_n(3);
        expv("t1_pre", 1, 0, 1,0, 1,0, 0,0, 1,0, 0);
        cyc_n(1);
        expv("t1_tick", 1, 0, 0,59, 1,0, 0,0, 1,0, 0);
        cyc_n(8);
        expv("t1_057", 1, 0, 0,57, 1,0, 0,0, 1,0, 0);

        // T2: move with 5 s increment, prescaler restarts on p1
        do_move(5);
        expv("t2_move", 1, 1, 1,2, 1,0, 0,0, 1,0, 0);
        cyc_n(3);
        expv("t2_pre", 1, 1, 1,2, 1,0, 0,0, 1,0, 0);
        cyc_n(1);
        expv("t2_p1tick", 1, 1, 1,2, 0,59, 0,0, 1,0, 0);

        // T4: pause mid-count, 20 clocks frozen, resume without lost tick
        cyc_n(2);
        do_pause();
        expv("t4_pause", 1, 1, 1,2, 0,59, 0,0, 0,0, 0);
        cyc_n(20);
        expv("t4_frozen", 1, 1, 1,2, 0,59, 0,0, 0,0, 0);
        do_start();
        expv("t4_resume", 1, 1, 1,2, 0,59, 0,0, 1,0, 0);
        cyc_n(1);
        expv("t4_notyet", 1, 1, 1,2, 0,59, 0,0, 1,0, 0);
        cyc_n(1);
        expv("t4_tick", 1, 1, 1,2, 0,58, 0,0, 1,0, 0);

        // pause on the tick cycle: tick dropped, fires right after resume
        cyc_n(3);
        do_pause();
        expv("pt_pause", 1, 1, 1,2, 0,58, 0,0, 0,0, 0);
        do_start();
        expv("pt_resume", 1, 1, 1,2, 0,58, 0,0, 1,0, 0);
        cyc_n(1);
        expv("pt_fire", 1, 1, 1,2, 0,57, 0,0, 1,0, 0);

        // T3: p1 runs down to 0:01 then flags
        cyc_n(224);
        expv("t3_001", 1, 1, 1,2, 0,1, 0,0, 1,0, 0);
        cyc_n(4);
        expv("t3_flag", 1, 1, 1,2, 0,0, 0,0, 0,1, 1);
        do_start();
        do_move(5);
        expv("t3_ignored", 1, 1, 1,2, 0,0, 0,0, 0,1, 1);

        // T6: load mid-FLAG, then move on the tick that reaches 0:00
        do_load(1);
        expv("t6_load", 1, 0, 1,0, 1,0, 0,0, 0,0, 0);
        do_start();
        cyc_n(236);
        expv("t6_001", 1, 0, 0,1, 1,0, 0,0, 1,0, 0);
        cyc_n(3);
        do_move(5);
        expv("t6_flag", 1, 0, 0,0, 1,0, 0,0, 0,1, 0);

        // zero time at start: one RUN cycle then FLAG
        do_load(0);
        expv("z_load", 1, 0, 0,0, 0,0, 0,0, 0,0, 0);
        do_start();
        expv("z_run", 1, 0, 0,0, 0,0, 0,0, 1,0, 0);
        cyc_n(1);
        expv("z_flag", 1, 0, 0,0, 0,0, 0,0, 0,1, 0);

        // T5 on the 3-player instance: saturation and active wrap
        do_load(63);
        expv("t5_load", 2, 0, 63,0, 63,0, 63,0, 0,0, 0);
        do_start();
        do_move(0);
        do_move(0);
        do_move(58);
        expv("t5_set", 2, 0, 63,0, 63,0, 63,58, 1,0, 0);
        do_move(0);
        do_move(0);
        expv("t5_act2", 2, 2, 63,0, 63,0, 63,58, 1,0, 0);
        do_move(10);
        expv("t5_sat", 2, 0, 63,0, 63,0, 63,59, 1,0, 0);
        // move on tick with an out-of-range increment (clamped to 59)
        cyc_n(3);
        do_move(63);
        expv("t5_mvtick", 2, 1, 63,58, 63,0, 63,59, 1,0, 0);
        cyc_n(4);
        expv("t5_p1tick", 2, 1, 63,58, 62,59, 63,59, 1,0, 0);

        // reset asserted mid-RUN
        cyc_n(2);
        reset_n = 1'b0;
        expv("rst_mid2", 2, 0, 0,0, 0,0, 0,0, 0,0, 0);
        expv("rst_mid1", 1, 0, 0,0, 0,0, 0,0, 0,0, 0);
        cyc_n(1);
        reset_n = 1'b1;
        cyc_n(1);
        expv("post_rst", 2, 0, 0,0, 0,0, 0,0, 0,0, 0);

        cyc_n(2);
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
